// File: rtl/state_collector_if.sv
`default_nettype none
// ============================================================================
// state_collector_if : byte-stream input and 4x4 block output bundle
// Rev 1.0 : initial release
// ============================================================================
interface state_collector_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       in_dir;
  logic       abort;
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] c0, c1, c2, c3;
  logic [7:0] d0, d1, d2, d3;
  logic       s7;
  logic       blk_valid;
  logic       blk_ready;
  logic [4:0] fill_cnt;
  logic [7:0] chk;

  modport master (
    output in_byte, in_valid, in_dir, abort, blk_ready,
    input  in_ready, a0, a1, a2, a3, b0, b1, b2, b3,
           c0, c1, c2, c3, d0, d1, d2, d3, s7, blk_valid, fill_cnt, chk
  );

  modport slave (
    input  in_byte, in_valid, in_dir, abort, blk_ready,
    output in_ready, a0, a1, a2, a3, b0, b1, b2, b3,
           c0, c1, c2, c3, d0, d1, d2, d3, s7, blk_valid, fill_cnt, chk
  );
endinterface
`default_nettype wire

// File: rtl/state_collector.sv
`default_nettype none
// ============================================================================
// state_collector : gathers 16 serial bytes into a 4x4 state matrix and hands
//                   it downstream with a valid/ready handshake.
// Option macro    : STATE_CHECKSUM_EN (running XOR checksum of the block)
// Rev 1.0 : initial release
// ============================================================================
module state_collector (
  input  wire logic        clk,
  input  wire logic        rst_n,
  state_collector_if.slave bus
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       fill_cnt_q, fill_cnt_d;
  logic [15:0][7:0] mat_q, mat_d;
  logic             s7_q, s7_d;
  logic             accept;

  // abort has priority over in_valid, so an aborted byte is never stored
  assign accept = (state_q == ST_FILL) && bus.in_valid && !bus.abort;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    mat_d      = mat_q;
    s7_d       = s7_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          mat_d[fill_cnt_q[3:0]] = bus.in_byte;
          if (fill_cnt_q == 5'd0) begin
            s7_d = bus.in_dir;
          end
          fill_cnt_d = fill_cnt_q + 5'd1;
          if (fill_cnt_q == 5'd15) begin
            state_d = ST_FULL;
          end
        end else if (bus.abort) begin
          fill_cnt_d = 5'd0;
        end
      end
      ST_FULL: begin
        if (bus.blk_ready) begin
          state_d    = ST_FILL;
          fill_cnt_d = 5'd0;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= 5'd0;
      mat_q      <= '0;
      s7_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      mat_q      <= mat_d;
      s7_q       <= s7_d;
    end
  end

`ifdef STATE_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       chk_clr;

  assign chk_clr = ((state_q == ST_FILL) && bus.abort) ||
                   ((state_q == ST_FULL) && bus.blk_ready);

  always_comb begin
    chk_d = chk_q;
    if (chk_clr) begin
      chk_d = 8'h00;
    end else if (accept) begin
      chk_d = chk_q ^ bus.in_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= 8'h00;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign bus.chk = chk_q;
`else
  assign bus.chk = 8'h00;
`endif

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.blk_valid = (state_q == ST_FULL);
  assign bus.fill_cnt  = fill_cnt_q;
  assign bus.s7        = s7_q;

  assign bus.a0 = mat_q[0];
  assign bus.a1 = mat_q[1];
  assign bus.a2 = mat_q[2];
  assign bus.a3 = mat_q[3];
  assign bus.b0 = mat_q[4];
  assign bus.b1 = mat_q[5];
  assign bus.b2 = mat_q[6];
  assign bus.b3 = mat_q[7];
  assign bus.c0 = mat_q[8];
  assign bus.c1 = mat_q[9];
  assign bus.c2 = mat_q[10];
  assign bus.c3 = mat_q[11];
  assign bus.d0 = mat_q[12];
  assign bus.d1 = mat_q[13];
  assign bus.d2 = mat_q[14];
  assign bus.d3 = mat_q[15];

endmodule
`default_nettype wire
